// File: rtl/nor_reduce_pipe_pkg.sv
// nor_reduce_pipe_pkg: mode encodings and per-bit lane reduction shared by the reduction pipe
package nor_reduce_pkg;
  localparam int MODE_W = 3;
  localparam int MAX_IN = 16;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_AND  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  // Reduces one bit column across the first n lanes; returns {err, result}.
  // Illegal modes force the result to 0 and raise err.
  function automatic logic [1:0] reduce_lanes(input logic [MODE_W-1:0] mode,
                                              input logic [MAX_IN-1:0] lanes,
                                              input int n);
    logic r_or, r_and, r_xor, r;
    r_or = 1'b0;
    r_and = 1'b1;
    r_xor = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        r_or = r_or | lanes[i];
        r_and = r_and & lanes[i];
        r_xor = r_xor ^ lanes[i];
      end
    end
    r = mode == MODE_NOR  ? !r_or  :
        mode == MODE_OR   ?  r_or  :
        mode == MODE_AND  ?  r_and :
        mode == MODE_NAND ? !r_and :
        mode == MODE_XOR  ?  r_xor :
        mode == MODE_XNOR ? !r_xor : 1'b0;
    return {mode > MODE_XNOR, r};
  endfunction
endpackage

// File: rtl/nor_reduce_pipe_if.sv
// nor_reduce_pipe_if: input and output valid/ready streams of the reduction pipe
interface nor_reduce_pipe_if #(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 1
);
  logic                          in_valid;
  logic                          in_ready;
  logic [nor_reduce_pkg::MODE_W-1:0] in_mode;
  logic [NUM_IN*WIDTH-1:0]       in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
  logic                          out_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/nor_reduce_pipe_stage.sv
// pipe_stage: one-deep valid/ready register slice with a parametrised payload
module pipe_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load on advance; payload only changes when a new item is actually taken
  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d  = ready_o && valid_i ? data_i : data_q;
  end

  // Slice state; reset empties the slice and clears the payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/nor_reduce_pipe.sv
// nor_reduce_pipe: two-stage registered multi-lane bitwise reduction with backpressure
module nor_reduce_pipe
  import nor_reduce_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 1
) (
  input logic              clk,
  input logic              rst_n,
  nor_reduce_pipe_if.slave bus
);
  localparam int DW = NUM_IN * WIDTH;

  logic                     s1_valid, s2_ready;
  logic [MODE_W+DW-1:0]     s1_payload;
  logic [MODE_W-1:0]        s1_mode;
  logic [DW-1:0]            s1_data;
  logic [MAX_IN-1:0]        col;
  logic [WIDTH-1:0]         res, errs;
  logic [WIDTH:0]           s2_payload;

  assign {s1_mode, s1_data} = s1_payload;
  assign {bus.out_err, bus.out_data} = s2_payload;

  pipe_stage #(.W(MODE_W + DW)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (bus.in_valid),
    .ready_o (bus.in_ready),
    .data_i  ({bus.in_mode, bus.in_data}),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_payload)
  );

  // Gather each bit column across lanes and reduce it under the registered mode
  always_comb begin
    col  = '0;
    res  = '0;
    errs = '0;
    for (int b = 0; b < WIDTH; b++) begin
      col = '0;
      for (int i = 0; i < NUM_IN; i++) col[i] = s1_data[i*WIDTH+b];
      {errs[b], res[b]} = reduce_lanes(s1_mode, col, NUM_IN);
    end
  end

  pipe_stage #(.W(WIDTH + 1)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  ({|errs, res}),
    .valid_o (bus.out_valid),
    .ready_i (bus.out_ready),
    .data_o  (s2_payload)
  );
endmodule

// File: tb/tb_nor_reduce_pipe.sv
// tb_nor_reduce_pipe: randomized and directed checks of the reduction pipe against a counting model
module tb_nor_reduce_pipe;
  import nor_reduce_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nor_reduce_pipe_if #(.NUM_IN(2), .WIDTH(1)) a ();
  nor_reduce_pipe_if #(.NUM_IN(4), .WIDTH(8)) b ();

  nor_reduce_pipe #(.NUM_IN(2), .WIDTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  nor_reduce_pipe #(.NUM_IN(4), .WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  // Reference: count set lanes per bit column and decide from the count
  function automatic logic [64:0] model(int n, int w, logic [2:0] m, logic [1023:0] d);
    logic [63:0] r;
    int cnt;
    r = '0;
    if (m > 3'd5) return {1'b1, 64'b0};
    for (int k = 0; k < w; k++) begin
      cnt = 0;
      for (int i = 0; i < n; i++) cnt += int'(d[i*w+k]);
      case (m)
        3'd0: r[k] = cnt == 0;
        3'd1: r[k] = cnt != 0;
        3'd2: r[k] = cnt == n;
        3'd3: r[k] = cnt != n;
        3'd4: r[k] = cnt % 2 == 1;
        default: r[k] = cnt % 2 == 0;
      endcase
    end
    return {1'b0, r};
  endfunction

  function automatic logic [8:0] exp_b(logic [2:0] m, logic [31:0] d);
    logic [1023:0] p;
    logic [64:0] r;
    p = '0;
    p[31:0] = d;
    r = model(4, 8, m, p);
    return {r[64], r[7:0]};
  endfunction

  task automatic idle_inputs();
    a.in_valid = 0; a.in_mode = '0; a.in_data = '0; a.out_ready = 0;
    b.in_valid = 0; b.in_mode = '0; b.in_data = '0; b.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_a_out_valid got=%b want=0", a.out_valid); end
    total++; if (a.out_data !== 1'b0) begin bad++; $display("FAIL reset_a_out_data got=%h want=0", a.out_data); end
    total++; if (a.out_err !== 1'b0) begin bad++; $display("FAIL reset_a_out_err got=%b want=0", a.out_err); end
    total++; if (a.in_ready !== 1'b1) begin bad++; $display("FAIL reset_a_in_ready got=%b want=1", a.in_ready); end
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL reset_b_out_valid got=%b want=0", b.out_valid); end
    total++; if (b.out_data !== 8'h00) begin bad++; $display("FAIL reset_b_out_data got=%h want=00", b.out_data); end
    total++; if (b.out_err !== 1'b0) begin bad++; $display("FAIL reset_b_out_err got=%b want=0", b.out_err); end
    total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL reset_b_in_ready got=%b want=1", b.in_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // 2-lane 1-bit NOR truth table streamed back to back
  task automatic test_nor_basic();
    logic exp_v;
    a.out_ready = 1;
    a.in_mode = MODE_NOR;
    for (int c = 0; c < 7; c++) begin
      a.in_valid = c < 4;
      a.in_data = 2'(c);
      @(negedge clk);
      if (c < 4) begin
        total++; if (a.in_ready !== 1'b1) begin bad++; $display("FAIL nor_in_ready c=%0d got=%b want=1", c, a.in_ready); end
      end
      exp_v = c >= 2 && c <= 5;
      total++; if (a.out_valid !== exp_v) begin bad++; $display("FAIL nor_out_valid c=%0d got=%b want=%b", c, a.out_valid, exp_v); end
      if (exp_v) begin
        total++; if (a.out_data !== 1'(c == 2)) begin bad++; $display("FAIL nor_out_data c=%0d got=%b want=%b", c, a.out_data, c == 2); end
      end
      @(posedge clk); #1;
    end
    a.in_valid = 0;
  endtask

  // 4x8 directed modes on fixed lane patterns
  task automatic test_modes();
    logic [2:0]  m[6] = '{MODE_OR, MODE_NOR, MODE_AND, MODE_XOR, MODE_NAND, MODE_XNOR};
    logic [31:0] d[6] = '{32'h0000F00F, 32'h0000F00F, 32'h0000F00F, 32'h0000F00F, 32'hFFFFFFFF, 32'h0000F00F};
    logic [7:0]  e[6] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    int sent = 0, got = 0, cyc = 0;
    bit fi;
    b.out_ready = 1;
    while (got < 6 && cyc < 50) begin
      b.in_valid = sent < 6;
      b.in_mode = m[sent < 6 ? sent : 0];
      b.in_data = d[sent < 6 ? sent : 0];
      @(negedge clk);
      fi = b.in_valid && b.in_ready;
      if (b.out_valid && b.out_ready) begin
        total++; if (b.out_data !== e[got] || b.out_err !== 1'b0) begin bad++; $display("FAIL modes idx=%0d got=%h/%b want=%h/0", got, b.out_data, b.out_err, e[got]); end
        got++;
      end
      @(posedge clk); #1;
      if (fi) sent++;
      cyc++;
    end
    total++; if (got != 6) begin bad++; $display("FAIL modes_timeout got=%0d want=6", got); end
    b.in_valid = 0;
  endtask

  // Stall the output for 5 cycles while streaming 4 random items
  task automatic test_backpressure();
    logic [2:0] m[4];
    logic [31:0] d[4];
    logic [8:0] r;
    int sent = 0, got = 0, cyc = 0;
    bit fi;
    for (int i = 0; i < 4; i++) begin m[i] = 3'($urandom_range(0, 5)); d[i] = $urandom; end
    while (got < 4 && cyc < 50) begin
      b.in_valid = sent < 4;
      b.in_mode = m[sent < 4 ? sent : 0];
      b.in_data = d[sent < 4 ? sent : 0];
      b.out_ready = cyc >= 5;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        total++; if (b.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, b.in_ready); end
        total++; if (b.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", cyc, b.out_valid); end
      end
      fi = b.in_valid && b.in_ready;
      if (b.out_valid && b.out_ready) begin
        r = exp_b(m[got], d[got]);
        total++; if ({b.out_err, b.out_data} !== r) begin bad++; $display("FAIL bp_data idx=%0d got=%b/%h want=%b/%h", got, b.out_err, b.out_data, r[8], r[7:0]); end
        got++;
      end
      @(posedge clk); #1;
      if (fi) sent++;
      cyc++;
    end
    total++; if (got != 4) begin bad++; $display("FAIL bp_timeout got=%0d want=4", got); end
    b.in_valid = 0;
  endtask

  // Illegal mode flags only its own transaction
  task automatic test_illegal();
    logic [2:0] m[2] = '{3'd7, MODE_OR};
    logic [8:0] e[2] = '{9'h100, 9'h0AA};
    int sent = 0, got = 0, cyc = 0;
    bit fi;
    b.out_ready = 1;
    b.in_data = 32'h000000AA;
    while (got < 2 && cyc < 30) begin
      b.in_valid = sent < 2;
      b.in_mode = m[sent < 2 ? sent : 0];
      @(negedge clk);
      fi = b.in_valid && b.in_ready;
      if (b.out_valid && b.out_ready) begin
        total++; if ({b.out_err, b.out_data} !== e[got]) begin bad++; $display("FAIL illegal idx=%0d got=%b/%h want=%b/%h", got, b.out_err, b.out_data, e[got][8], e[got][7:0]); end
        got++;
      end
      @(posedge clk); #1;
      if (fi) sent++;
      cyc++;
    end
    total++; if (got != 2) begin bad++; $display("FAIL illegal_timeout got=%0d want=2", got); end
    b.in_valid = 0;
  endtask

  // 16 random items with the consumer always ready: one result per cycle
  task automatic test_back_to_back();
    logic [2:0] m[16];
    logic [31:0] d[16];
    logic [8:0] r;
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    for (int i = 0; i < 16; i++) begin m[i] = 3'($urandom_range(0, 7)); d[i] = $urandom; end
    b.out_ready = 1;
    while (got < 16 && cyc < 60) begin
      b.in_valid = sent < 16;
      b.in_mode = m[sent < 16 ? sent : 0];
      b.in_data = d[sent < 16 ? sent : 0];
      @(negedge clk);
      if (sent < 16) begin
        total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, b.in_ready); end
      end
      if (b.out_valid) begin
        r = exp_b(m[got], d[got]);
        total++; if ({b.out_err, b.out_data} !== r) begin bad++; $display("FAIL b2b_data idx=%0d got=%b/%h want=%b/%h", got, b.out_err, b.out_data, r[8], r[7:0]); end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (sent < 16) sent++;
      cyc++;
    end
    total++; if (first != 2) begin bad++; $display("FAIL b2b_latency got=%0d want=2", first); end
    total++; if (last - first != 15 || got != 16) begin bad++; $display("FAIL b2b_span got=%0d/%0d want=15/16", last - first, got); end
    b.in_valid = 0;
  endtask

  // Random gaps and random consumer stalls, also checking output stability under stall
  task automatic test_random_stream();
    logic [2:0] m[64];
    logic [31:0] d[64];
    logic [8:0] r;
    logic [8:0] pd = '0;
    int sent = 0, got = 0, cyc = 0;
    bit offer = 0, fi, pv = 0;
    for (int i = 0; i < 64; i++) begin m[i] = 3'($urandom_range(0, 7)); d[i] = $urandom; end
    while (got < 40 && cyc < 2000) begin
      if (!offer) offer = sent < 40 && $urandom_range(0, 3) != 0;
      b.in_valid = offer;
      b.in_mode = m[sent];
      b.in_data = d[sent];
      b.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pv) begin
        total++; if (b.out_valid !== 1'b1 || {b.out_err, b.out_data} !== pd) begin bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h want=1/%h", cyc, b.out_valid, {b.out_err, b.out_data}, pd); end
      end
      fi = b.in_valid && b.in_ready;
      if (b.out_valid && b.out_ready) begin
        r = exp_b(m[got], d[got]);
        total++; if ({b.out_err, b.out_data} !== r) begin bad++; $display("FAIL rnd_data idx=%0d got=%b/%h want=%b/%h", got, b.out_err, b.out_data, r[8], r[7:0]); end
        got++;
      end
      pv = b.out_valid && !b.out_ready;
      pd = {b.out_err, b.out_data};
      @(posedge clk); #1;
      if (fi) begin sent++; offer = 0; end
      cyc++;
    end
    total++; if (got != 40) begin bad++; $display("FAIL rnd_timeout got=%0d want=40", got); end
    b.in_valid = 0;
  endtask

  // Asynchronous reset with two items in flight discards both
  task automatic test_reset_flight();
    b.out_ready = 0;
    b.in_mode = MODE_OR;
    for (int c = 0; c < 2; c++) begin
      b.in_valid = 1;
      b.in_data = 32'h000000FF + 32'(c);
      @(posedge clk); #1;
    end
    b.in_valid = 0;
    @(negedge clk);
    total++; if (b.out_valid !== 1'b1 || b.in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%b/%b want=1/0", b.out_valid, b.in_ready); end
    #2 rst_n = 0;
    #1;
    total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rf_out_valid got=%b want=0", b.out_valid); end
    total++; if (b.out_data !== 8'h00 || b.out_err !== 1'b0) begin bad++; $display("FAIL rf_out_data got=%b/%h want=0/00", b.out_err, b.out_data); end
    total++; if (b.in_ready !== 1'b1) begin bad++; $display("FAIL rf_in_ready got=%b want=1", b.in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    b.out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (b.out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale c=%0d got=%b want=0", c, b.out_valid); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_nor_basic();
    test_modes();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random_stream();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
